// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dlymon_pkg.sv
// Shared types and constants for the delay-line ring-oscillator monitor.
// The window is a whole number of WIN_BASE-cycle blocks.
package gf180mcu_fd_sc_mcu7t5v0__dlymon_pkg;

  localparam int WIN_BASE = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_COUNT  = 2'd2,
    ST_DONE   = 2'd3
  } dlymon_state_e;

  // Terminal-count load for the window down-counter (length - 1).
  function automatic logic [7:0] window_last(input logic [3:0] win);
    return 8'(WIN_BASE * (int'(win) + 1) - 1);
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dlymon_sync.sv
// RO_IN synchronizer followed by a single-cycle rising-edge detector.
// The edge flop is reset with the chain so nothing is seen until a real 0->1 passes through.
module gf180mcu_fd_sc_mcu7t5v0__dlymon_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dlymon.sv
// Ring-oscillator delay monitor: counts RO_IN rising edges over a 16*(WIN+1)-cycle window.
// Build option DLYMON_SATURATE_EN: counter saturates instead of wrapping on overflow.
//
// state  | meaning
// IDLE   | waiting for START, oscillator off
// SETTLE | oscillator on, synchronizer flushing, no counting
// COUNT  | window running, synchronized rising edges counted
// DONE   | result loaded into CNT/OVF, one-cycle DONE pulse
module gf180mcu_fd_sc_mcu7t5v0__dlymon
  import gf180mcu_fd_sc_mcu7t5v0__dlymon_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [3:0]       WIN,
  input  logic             RO_IN,
  output logic             RO_EN,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] CNT,
  output logic             OVF,
  inout  wire              VDD,
  inout  wire              VSS
);

  localparam logic [7:0] SETTLE_LOAD = 8'(SYNC_STAGES);

  dlymon_state_e    state;
  logic [7:0]       timer;
  logic [3:0]       win_q;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] edge_cnt_nxt;
  logic             edge_ovf;
  logic             edge_ovf_nxt;
  logic             rise;

  wire unused_supply = VDD ^ VSS;

  gf180mcu_fd_sc_mcu7t5v0__dlymon_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (CLK),
    .rst  (RST),
    .din  (RO_IN),
    .rise (rise)
  );

  always_comb begin
    edge_cnt_nxt = edge_cnt;
    edge_ovf_nxt = edge_ovf;
    if (rise) begin
`ifdef DLYMON_SATURATE_EN
      if (edge_cnt == '1) edge_ovf_nxt = 1'b1;
      else                edge_cnt_nxt = edge_cnt + 1'b1;
`else
      edge_cnt_nxt = edge_cnt + 1'b1;
      if (edge_cnt == '1) edge_ovf_nxt = 1'b1;
`endif
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_IDLE;
      timer    <= '0;
      win_q    <= '0;
      edge_cnt <= '0;
      edge_ovf <= 1'b0;
      RO_EN    <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      CNT      <= '0;
      OVF      <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            state <= ST_SETTLE;
            win_q <= WIN;
            timer <= SETTLE_LOAD;
            RO_EN <= 1'b1;
            BUSY  <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (timer == '0) begin
            state    <= ST_COUNT;
            timer    <= window_last(win_q);
            edge_cnt <= '0;
            edge_ovf <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_COUNT: begin
          edge_cnt <= edge_cnt_nxt;
          edge_ovf <= edge_ovf_nxt;
          // The edge landing on the last window cycle still belongs to the result.
          if (timer == '0) begin
            state <= ST_DONE;
            RO_EN <= 1'b0;
            DONE  <= 1'b1;
            CNT   <= edge_cnt_nxt;
            OVF   <= edge_ovf_nxt;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__dlymon.sv
// Scoreboard bench for the delay monitor: two instances (16-bit and 4-bit counters) share stimulus.
// Expected counts come from the recorded RO_IN sample history over the measurement window.
module tb_gf180mcu_fd_sc_mcu7t5v0__dlymon;

  localparam int SYNC = 2;

  logic       CLK   = 1'b0;
  logic       RST   = 1'b1;
  logic       START = 1'b0;
  logic [3:0] WIN   = 4'd0;
  logic       RO_IN = 1'b0;
  wire        VDD;
  wire        VSS;
  assign VDD = 1'b1;
  assign VSS = 1'b0;

  logic        ro_en_a, busy_a, done_a, ovf_a;
  logic [15:0] cnt_a;
  logic        ro_en_b, busy_b, done_b, ovf_b;
  logic [3:0]  cnt_b;

  gf180mcu_fd_sc_mcu7t5v0__dlymon #(.CNT_W(16), .SYNC_STAGES(SYNC)) dut_a (
    .CLK(CLK), .RST(RST), .START(START), .WIN(WIN), .RO_IN(RO_IN),
    .RO_EN(ro_en_a), .BUSY(busy_a), .DONE(done_a), .CNT(cnt_a), .OVF(ovf_a),
    .VDD(VDD), .VSS(VSS));

  gf180mcu_fd_sc_mcu7t5v0__dlymon #(.CNT_W(4), .SYNC_STAGES(SYNC)) dut_b (
    .CLK(CLK), .RST(RST), .START(START), .WIN(WIN), .RO_IN(RO_IN),
    .RO_EN(ro_en_b), .BUSY(busy_b), .DONE(done_b), .CNT(cnt_b), .OVF(ovf_b),
    .VDD(VDD), .VSS(VSS));

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // RO_IN generator: 0 = periodic pulse, 1 = constant level, 2 = random gaps (spacing >= 2)
  int ro_mode  = 1;
  int ro_per   = 4;
  bit ro_level = 1'b0;
  int ro_ph    = 0;
  int ro_gap   = 2;

  always @(posedge CLK) begin
    #1;
    case (ro_mode)
      0: begin
        RO_IN = (ro_ph % ro_per) == 0;
        ro_ph++;
      end
      2: begin
        if (ro_gap <= 1) begin
          RO_IN  = 1'b1;
          ro_gap = $urandom_range(2, 6);
        end else begin
          RO_IN = 1'b0;
          ro_gap--;
        end
      end
      default: RO_IN = ro_level;
    endcase
  end

  // Reference model: records what every clock edge saw and when a measurement is accepted.
  typedef struct {
    int acc;
    int len;
    int done_edge;
  } exp_t;

  exp_t q[$];
  bit   samp [0:65535];
  int   cyc       = 0;
  int   next_free = 0;

  always @(posedge CLK) begin : model
    exp_t e;
    samp[cyc] = RO_IN;
    if (RST) begin
      q.delete();
      next_free = cyc + 1;
    end else if (START && cyc >= next_free) begin
      e.acc       = cyc;
      e.len       = 16 * (WIN + 1);
      e.done_edge = cyc + SYNC + 1 + e.len;
      q.push_back(e);
      next_free = e.done_edge + 2;
    end
    cyc++;
  end

  // Sample j is counted when it is a 0->1 step and lies in the window [acc+2, acc+len+1].
  function automatic int count_rises(input int lo, input int hi);
    int n = 0;
    for (int j = lo; j <= hi; j++)
      if (samp[j] && !samp[j-1]) n++;
    return n;
  endfunction

  longint held_cnt_a = 0, held_cnt_b = 0;
  longint held_ovf_a = 0, held_ovf_b = 0;

  always @(negedge CLK) begin : monitor
    int last;
    int n;
    bit e_busy, e_roen, e_done;
    last   = cyc - 1;
    e_busy = 1'b0;
    e_roen = 1'b0;
    e_done = 1'b0;
    if (RST) begin
      q.delete();
      held_cnt_a = 0; held_ovf_a = 0;
      held_cnt_b = 0; held_ovf_b = 0;
    end else if (q.size() > 0 && q[0].acc <= last) begin
      e_busy = 1'b1;
      if (last < q[0].done_edge) begin
        e_roen = 1'b1;
      end else begin
        e_done = 1'b1;
        n = count_rises(q[0].acc + 2, q[0].acc + q[0].len + 1);
`ifdef DLYMON_SATURATE_EN
        held_cnt_a = (n > 65535) ? 65535 : n;
        held_ovf_a = (n > 65535);
        held_cnt_b = (n > 15) ? 15 : n;
        held_ovf_b = (n > 15);
`else
        held_cnt_a = n % 65536;
        held_ovf_a = (n >= 65536);
        held_cnt_b = n % 16;
        held_ovf_b = (n >= 16);
`endif
        q.delete(0);
      end
    end
    check("done_a",  done_a,  e_done);
    check("busy_a",  busy_a,  e_busy);
    check("ro_en_a", ro_en_a, e_roen);
    check("cnt_a",   cnt_a,   held_cnt_a);
    check("ovf_a",   ovf_a,   held_ovf_a);
    check("done_b",  done_b,  e_done);
    check("busy_b",  busy_b,  e_busy);
    check("ro_en_b", ro_en_b, e_roen);
    check("cnt_b",   cnt_b,   held_cnt_b);
    check("ovf_b",   ovf_b,   held_ovf_b);
  end

  task automatic measure(input logic [3:0] w);
    WIN   = w;
    START = 1'b1;
    tick(1);
    START = 1'b0;
    tick(16 * (int'(w) + 1) + SYNC + 8);
  endtask

  initial begin
    tick(3);
    check("rst_cnt_a", cnt_a, 0);
    check("rst_busy_a", busy_a, 0);
    RST = 1'b0;
    tick(2);

    // Edge every 4 cycles, shortest window.
    ro_mode = 0; ro_per = 4;
    measure(4'd0);

    // Edge every 2 cycles, longest window.
    ro_per = 2;
    measure(4'd15);

    // 16 edges in 32 cycles overflows the 4-bit instance.
    measure(4'd1);

    // Input stuck high: the settle flush must not produce a count.
    ro_mode = 1; ro_level = 1'b1;
    tick(3);
    measure(4'd0);
    ro_level = 1'b0;

    // START re-pulsed during COUNT is ignored.
    ro_mode = 0; ro_per = 3;
    WIN = 4'd2; START = 1'b1; tick(1); START = 1'b0;
    tick(10);
    START = 1'b1; tick(1); START = 1'b0;
    tick(60);

    // Reset in the middle of COUNT aborts without DONE.
    ro_per = 4;
    WIN = 4'd3; START = 1'b1; tick(1); START = 1'b0;
    tick(7);
    RST = 1'b1;
    #1;
    check("abort_ro_en", ro_en_a, 0);
    check("abort_busy",  busy_a,  0);
    check("abort_cnt",   cnt_a,   0);
    check("abort_ovf",   ovf_a,   0);
    tick(2);
    RST = 1'b0;
    tick(2);
    measure(4'd3);

    // START held high: back-to-back measurements.
    ro_mode = 2;
    WIN = 4'd0; START = 1'b1;
    tick(3 * (SYNC + 16 + 3) + 4);
    START = 1'b0;
    tick(30);

    // Randomized trials.
    for (int t = 0; t < 24; t++) begin
      int w;
      int sel;
      w   = $urandom_range(0, 3);
      sel = $urandom_range(0, 5);
      if (sel == 0) begin
        ro_mode = 1; ro_level = $urandom_range(0, 1);
      end else if (sel <= 2) begin
        ro_mode = 2;
      end else begin
        ro_mode = 0; ro_per = $urandom_range(2, 9); ro_ph = $urandom_range(0, 8);
      end
      WIN   = 4'(w);
      START = 1'b1;
      tick($urandom_range(1, 5));
      START = 1'b0;
      tick(16 * (w + 1) + SYNC + 4 + $urandom_range(0, 6));
    end

    tick(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__dlymon.md
GF180MCU_FD_SC_MCU7T5V0__DLYMON -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__dlymon

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the edge counter and the CNT result.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, flop depth of the RO_IN synchronizer (legal range 2..4).
REQ-003 SHALL have port CLK  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port START  input  1  measurement request, sampled only in IDLE.
REQ-006 SHALL have port WIN  input  4  window select; window length = 16*(WIN+1) CLK cycles, latched at accepted START.
REQ-007 SHALL have port RO_IN  input  1  asynchronous output of the external dlyd ring oscillator.
REQ-008 SHALL have port RO_EN  output  1  ring-oscillator enable, high in SETTLE and COUNT only.
REQ-009 SHALL have ports BUSY  output  1 (high outside IDLE) and DONE  output  1 (1-cycle result-valid pulse).
REQ-010 SHALL have ports CNT  output  CNT_W (rising edges of RO_IN counted in the last window) and OVF  output  1 (counter overflowed in the last window).
REQ-011 SHALL have ports VDD and VSS  inout  1  supply pins, functionally unused.

Function
REQ-012 FSM states SHALL be IDLE, SETTLE, COUNT, DONE.
REQ-013 IDLE -> SETTLE SHALL occur on the first edge with START=1; WIN is latched on that edge.
REQ-014 SETTLE SHALL last SYNC_STAGES+1 cycles with RO_EN=1; synchronizer flushes and no edges are counted.
REQ-015 On SETTLE -> COUNT the edge counter and overflow flag SHALL clear.
REQ-016 COUNT SHALL last exactly 16*(WIN+1) cycles; each synchronized 0->1 transition of RO_IN increments the counter by 1.
REQ-017 COUNT -> DONE SHALL drop RO_EN and load CNT and OVF from the counter; DONE=1 for exactly one cycle, then return to IDLE.
REQ-018 CNT and OVF SHALL hold their values until the next DONE, or until reset.
REQ-019 START while BUSY=1 SHALL be ignored and SHALL NOT be queued.
REQ-020 START held high SHALL begin a new measurement on the first IDLE cycle after DONE (back-to-back operation).
REQ-021 Counting SHALL be exact only for RO_IN rising-edge spacing of at least 2 CLK periods; faster input is undefined but SHALL NOT corrupt the FSM.

Reset
REQ-022 RST=1 SHALL immediately force IDLE, RO_EN=0, BUSY=0, DONE=0, CNT=0, OVF=0, synchronizer flops=0, counter=0.
REQ-023 RST asserted mid-SETTLE or mid-COUNT SHALL abort the measurement with no DONE pulse; the first START after release starts a clean measurement.

Configuration
REQ-024 Macro DLYMON_SATURATE_EN defined: counter SHALL stop at 2^CNT_W-1 and set OVF when a further edge arrives.
REQ-025 Macro DLYMON_SATURATE_EN undefined: counter SHALL wrap to 0 and set OVF sticky for that window.

Structure
REQ-026 Shared package gf180mcu_fd_sc_mcu7t5v0__dlymon_pkg SHALL hold the FSM state enum and the window base constant (16).
REQ-027 Synchronizer plus rising-edge detect SHALL be sub-module gf180mcu_fd_sc_mcu7t5v0__dlymon_sync; everything else is flat.

Verification
REQ-028 RO_IN rising edge every 4 cycles, WIN=0, START pulse -> DONE 1+3+16 cycles after the START edge (SYNC_STAGES=2), CNT=4, OVF=0.
REQ-029 RO_IN rising edge every 2 cycles, WIN=15 -> window 256 cycles, CNT=128, OVF=0.
REQ-030 CNT_W=4, RO_IN rising edge every 2 cycles, WIN=1 (32 cycles, 16 edges) -> with macro CNT=15, OVF=1; without macro CNT=0, OVF=1.
REQ-031 START re-pulsed during COUNT -> ignored; exactly one DONE pulse, and BUSY falls one cycle after DONE.
REQ-032 RST pulsed at COUNT cycle 5 -> RO_EN, BUSY, CNT, OVF all 0 immediately, no DONE pulse; the next START yields a correct CNT.
REQ-033 RO_IN held at 1 through the whole measurement -> CNT=0 (no edge is counted from the settle flush).
